apb_master: RTL and testbench

APB4 initiator that converts single requests on a valid/ready command channel into APB4 SETUP/ACCESS transfers and returns PRDATA/PSLVERR on a valid/ready response channel. It sits between the UVM-independent stimulus/CPU-side logic and APB responders such as the APB-mapped FIFO. It drives the FIFO's PADDR/PWRITE/PWDATA/PSTRB/PPROT/PSEL/PENABLE, and accepts wait states through PREADY.

---
 rtl/apb_pkg.sv | 27 ++
 rtl/apb_master_if.sv | 51 +++++
 rtl/apb_master_timeout.sv | 32 +++
 rtl/apb_master.sv | 125 ++++++++++++
 tb/tb_apb_master.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB4 initiator.
//   apb_mst_state_e : initiator FSM states (IDLE/SETUP/ACCESS/RESP)
//   apb_rsp_t       : captured response (rdata, err, timeout)
//   PPROT_*         : PPROT bit constants
// The response struct is sized by APB_DATA_W; apb_master's DATA_W must match it.
package apb_pkg;

  localparam int unsigned APB_DATA_W = 32;

  localparam logic [2:0] PPROT_PRIV   = 3'b001;
  localparam logic [2:0] PPROT_NONSEC = 3'b010;
  localparam logic [2:0] PPROT_INSTR  = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_if.sv
// Bundle of the command/response channels and the APB4 bus of apb_master.
//   master modport : the initiator's view (drives cmd_ready, rsp_*, APB request)
//   slave  modport : the stimulus/responder view (drives cmd_*, rsp_ready, APB completion)
interface apb_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [DATA_W/8-1:0]   cmd_strb;
  logic [2:0]            cmd_prot;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic [ADDR_W-1:0]     PADDR;
  logic [2:0]            PPROT;
  logic                  PWRITE;
  logic [DATA_W-1:0]     PWDATA;
  logic [DATA_W/8-1:0]   PSTRB;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PREADY;
  logic [DATA_W-1:0]     PRDATA;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PADDR, PPROT, PWRITE, PWDATA, PSTRB, PSEL, PENABLE,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PADDR, PPROT, PWRITE, PWDATA, PSTRB, PSEL, PENABLE,
    output PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/apb_master_timeout.sv
// ACCESS-phase wait-state watchdog for apb_master.
//   clk, rst : clock / async active-high reset
//   access   : FSM is in ACCESS this cycle
//   pready   : APB PREADY
//   expire   : this ACCESS cycle is the LIMIT-th consecutive wait cycle
module apb_master_timeout #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic access,
  input  logic pready,
  output logic expire
);

  logic [15:0] wait_cnt;

  // Held at zero outside ACCESS, so every ACCESS phase starts from a cleared count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!access) begin
      wait_cnt <= '0;
    end else if (!pready) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // PREADY in the limit cycle takes priority: expire is gated by ~pready.
  assign expire = access && !pready && (wait_cnt == 16'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// APB4 initiator: one valid/ready command -> one SETUP/ACCESS transfer ->
// one valid/ready response (rdata, PSLVERR, timeout).
//   PCLK, PRESET : clock / async active-high reset
//   bus          : apb_master_if.master (cmd_*, rsp_*, APB4 request/completion)
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES wait states (rsp_err=1, rsp_timeout=1, rsp_rdata=0).
// Without it the block waits for PREADY indefinitely and rsp_timeout is 0.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic          PCLK,
  input logic          PRESET,
  apb_master_if.master bus
);

  apb_mst_state_e      state, state_next;
  apb_rsp_t            rsp_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic                pwrite_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [DATA_W/8-1:0] pstrb_q;
  logic [2:0]          pprot_q;
  logic                accept;
  logic                complete;
  logic                expire;

  assign accept   = (state == IDLE) && bus.cmd_valid;
  assign complete = (state == ACCESS) && bus.PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (PCLK),
    .rst   (PRESET),
    .access(state == ACCESS),
    .pready(bus.PREADY),
    .expire(expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.cmd_valid) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (bus.PREADY || expire) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // PSEL/PENABLE/rsp_valid decode straight from the state register, so they
  // are glitch-free and drop asynchronously with PRESET.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.PSEL      = 1'b0;
    bus.PENABLE   = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state)
      IDLE:    bus.cmd_ready = ~PRESET;
      SETUP:   bus.PSEL      = 1'b1;
      ACCESS:  begin
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b1;
      end
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
      rsp_q    <= '0;
    end else begin
      if (accept) begin
        paddr_q  <= bus.cmd_addr;
        pwrite_q <= bus.cmd_write;
        pwdata_q <= bus.cmd_wdata;
        pstrb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
        pprot_q  <= bus.cmd_prot;
      end
      if (complete) begin
        rsp_q.rdata   <= pwrite_q ? '0 : bus.PRDATA;
        rsp_q.err     <= bus.PSLVERR;
        rsp_q.timeout <= 1'b0;
      end else if (expire) begin
        rsp_q.rdata   <= '0;
        rsp_q.err     <= 1'b1;
        rsp_q.timeout <= 1'b1;
      end
    end
  end

  assign bus.PADDR       = paddr_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;
  assign bus.PPROT       = pprot_q;
  assign bus.rsp_rdata   = rsp_q.rdata;
  assign bus.rsp_err     = rsp_q.err;
  assign bus.rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master.sv
// Directed, table-driven bench for apb_master with a small APB responder:
// 0x8000_0000 is a FIFO data port (write pushes, read pops, pop-empty errors),
// 0x0000_0040 always answers PSLVERR with PRDATA=0, any other address accepts
// writes and returns addr ^ 0x5A5A_5A5A on reads.
module tb_apb_master;
  import apb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [31:0] FIFO_ADDR = 32'h8000_0000;
  localparam logic [31:0] ERR_ADDR  = 32'h0000_0040;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK  (clk),
    .PRESET(rst),
    .bus   (bus.master)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int unsigned waits;
    int unsigned hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_pstrb;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] fifo_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic respond(output logic [31:0] prd, output logic perr);
    prd  = 32'h0;
    perr = 1'b0;
    if (bus.PADDR == ERR_ADDR) begin
      perr = 1'b1;
    end else if (bus.PADDR == FIFO_ADDR) begin
      if (bus.PWRITE) begin
        fifo_q.push_back(bus.PWDATA);
        prd = 32'hFFFF_FFFF;
      end else if (fifo_q.size() == 0) begin
        perr = 1'b1;
      end else begin
        prd = fifo_q.pop_front();
      end
    end else begin
      prd = bus.PWRITE ? 32'hFFFF_FFFF : (bus.PADDR ^ 32'h5A5A_5A5A);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] prd;
    logic        perr;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.write;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.cmd_strb  = v.strb;
    bus.cmd_prot  = v.prot;
    check("cmd_ready_idle", bus.cmd_ready, 1);
    @(posedge clk); #1;
    // Scramble the command so any unregistered path shows up on the bus.
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = ~v.addr;
    bus.cmd_wdata = ~v.wdata;
    bus.cmd_strb  = ~v.strb;
    bus.cmd_write = ~v.write;
    check("setup_sel_en", {bus.PSEL, bus.PENABLE}, 2'b10);
    check("setup_cmd_ready", bus.cmd_ready, 0);
    check("setup_paddr", bus.PADDR, v.addr);
    check("setup_pwrite", bus.PWRITE, v.write);
    check("setup_pwdata", bus.PWDATA, v.wdata);
    check("setup_pstrb", bus.PSTRB, v.exp_pstrb);
    check("setup_pprot", bus.PPROT, v.prot);
    @(posedge clk); #1;
    for (int w = 0; w <= int'(v.waits); w++) begin
      check("access_sel_en", {bus.PSEL, bus.PENABLE}, 2'b11);
      check("access_rsp_valid", bus.rsp_valid, 0);
      check("access_paddr", bus.PADDR, v.addr);
      check("access_pwdata", bus.PWDATA, v.wdata);
      check("access_pstrb", bus.PSTRB, v.exp_pstrb);
      if (w == int'(v.waits)) begin
        respond(prd, perr);
        bus.PREADY  = 1'b1;
        bus.PRDATA  = prd;
        bus.PSLVERR = perr;
      end else begin
        bus.PREADY  = 1'b0;
        bus.PRDATA  = 32'hDEAD_BEEF;
        bus.PSLVERR = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.PREADY  = 1'b0;
    bus.PRDATA  = 32'hBAD0_BAD0;
    bus.PSLVERR = ~bus.PSLVERR;
    for (int h = 0; h <= int'(v.hold); h++) begin
      check("resp_valid", bus.rsp_valid, 1);
      check("resp_sel_en", {bus.PSEL, bus.PENABLE}, 2'b00);
      check("resp_rdata", bus.rsp_rdata, v.exp_rdata);
      check("resp_err", bus.rsp_err, v.exp_err);
      check("resp_timeout", bus.rsp_timeout, 0);
      check("resp_cmd_ready", bus.cmd_ready, 0);
      check("resp_paddr_hold", bus.PADDR, v.addr);
      if (h < int'(v.hold)) begin
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("post_rsp_valid", bus.rsp_valid, 0);
    check("post_cmd_ready", bus.cmd_ready, 1);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_0020, 4'hF, 3'b000, 0, 0, 32'h0, 1'b0, 4'hF};
    vecs[1] = '{1'b1, FIFO_ADDR, 32'h0000_00A5, 4'hF, PPROT_PRIV, 0, 0, 32'h0, 1'b0, 4'hF};
    vecs[2] = '{1'b0, FIFO_ADDR, 32'h1234_5678, 4'hF, PPROT_NONSEC, 0, 0, 32'h0000_00A5, 1'b0, 4'h0};
    vecs[3] = '{1'b0, ERR_ADDR, 32'h0, 4'hF, 3'b000, 0, 0, 32'h0, 1'b1, 4'h0};
    vecs[4] = '{1'b1, FIFO_ADDR, 32'h0000_00C3, 4'h3, PPROT_INSTR, 3, 0, 32'h0, 1'b0, 4'h3};
    vecs[5] = '{1'b0, FIFO_ADDR, 32'h0, 4'hF, 3'b011, 1, 0, 32'h0000_00C3, 1'b0, 4'h0};
    vecs[6] = '{1'b1, ERR_ADDR, 32'h0000_0055, 4'h5, 3'b000, 2, 0, 32'h0, 1'b1, 4'h5};
    vecs[7] = '{1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'b000, 0, 5, 32'h5A5A_4A5A, 1'b0, 4'h0};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = '0;
    bus.PSLVERR   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_sel_en", {bus.PSEL, bus.PENABLE}, 2'b00);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_paddr", bus.PADDR, 0);
    check("rst_pstrb", bus.PSTRB, 0);
    check("rst_rsp_fields", {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_cmd_ready", bus.cmd_ready, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during ACCESS: bus drops immediately and the response is lost.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0000_1000;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.PREADY    = 1'b0;
    @(posedge clk); #1;
    check("mid_access_sel_en", {bus.PSEL, bus.PENABLE}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_sel_en", {bus.PSEL, bus.PENABLE}, 2'b00);
    check("mid_rst_cmd_ready", bus.cmd_ready, 0);
    check("mid_rst_paddr", bus.PADDR, 0);
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h1111_2222;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.PREADY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("post_rst_rsp_valid", bus.rsp_valid, 0);
      check("post_rst_cmd_ready", bus.cmd_ready, 1);
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // TIMEOUT_CYCLES=4 with PREADY stuck low: four ACCESS cycles, then abort.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0000_1000;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.PRDATA    = 32'hCAFE_F00D;
    check("to_setup_sel_en", {bus.PSEL, bus.PENABLE}, 2'b10);
    @(posedge clk); #1;
    for (int w = 0; w < 4; w++) begin
      check("to_access_sel_en", {bus.PSEL, bus.PENABLE}, 2'b11);
      check("to_access_rsp_valid", bus.rsp_valid, 0);
      @(posedge clk); #1;
    end
    check("to_sel_en", {bus.PSEL, bus.PENABLE}, 2'b00);
    check("to_rsp_valid", bus.rsp_valid, 1);
    check("to_rsp_err", bus.rsp_err, 1);
    check("to_rsp_timeout", bus.rsp_timeout, 1);
    check("to_rsp_rdata", bus.rsp_rdata, 0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("to_post_cmd_ready", bus.cmd_ready, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
